segment_scanner: RTL and testbench
==================================

# segment_scanner

Parametrised time-multiplexed driver for common-anode/cathode segment displays. It scans `NUM_DIGITS` digits with a blanking dead-time per slot to suppress ghosting. It also provides PWM brightness, per-digit enable and blink, and a double-buffered character load that only takes effect at frame boundaries. It sits between the display-content logic and the board pins, clocked by the already-divided scan clock.

## Interface
- `NUM_DIGITS`, default 4: digits scanned; minimum 2.
- `SEG_WIDTH`, default 8: segment lines per digit, including DP.
- `BRIGHT_WIDTH`, default 4: brightness width. Slot length is `SLOT_TICKS = 2**BRIGHT_WIDTH` clk_div cycles.
- `BLINK_FRAMES`, default 64: frames per blink half-period; minimum 1.
- `ADDR_ACTIVE_LOW`, default 0: 1 inverts all `out_addr` bits.
- `SEG_ACTIVE_LOW`, default 0: 1 inverts all `out_data` bits.

Ports:
- `clk_div` input 1: scan clock.
- `rst` input 1: reset, asynchronous, active-high.
- `chars` input `[NUM_DIGITS-1:0][SEG_WIDTH-1:0]`: segment patterns, sampled only when `load`=1.
- `load` input 1: capture `chars` into the shadow buffer.
- `brightness` input `BRIGHT_WIDTH`: on-ticks per slot; 0 = dark.
- `digit_en` input `NUM_DIGITS`: per-digit enable.
- `blink_mask` input `NUM_DIGITS`: digits blanked during the blink-off phase.
- `out_addr` output `NUM_DIGITS`: one-hot digit select, or all-inactive.
- `out_data` output `SEG_WIDTH`: segment lines.
- `update_pending` output 1: shadow buffer not yet transferred to display.
- `frame_start` output 1: one-cycle pulse aligned with the first output cycle of digit 0.

## Operation
- **State:** digit index `d` (0..NUM_DIGITS-1), slot tick `t` (0..SLOT_TICKS-1), frame counter `f` (0..BLINK_FRAMES-1), `blink_phase`, `shadow` buffer, `display` buffer, `pending`.
- **Counters:**
  - `t` increments every cycle.
  - When `t` = SLOT_TICKS-1, `t` goes to 0 and `d` increments, wrapping from NUM_DIGITS-1 to 0.
  - The wrap of `d` from (NUM_DIGITS-1, SLOT_TICKS-1) is the frame end.
- **Blink:** at each frame end `f` increments. At `f` = BLINK_FRAMES-1, `f` goes to 0 and `blink_phase` toggles. `blink_phase` changes only at frame ends.
- **Load and transfer:**
  - A `load` cycle writes `shadow <= chars` and `pending <= 1`.
  - At a frame end with `pending` = 1, `display <= shadow` and `pending <= 0`.
  - If `load`=1 on a frame-end cycle, `display <= chars` directly and `pending` stays 0.
  - Back-to-back loads overwrite `shadow`; the last one wins.
- **Lit condition:** the slot is lit when all of the following hold:
  - `t` != 0 (tick 0 is the dead-time);
  - `t` <= `brightness`;
  - `digit_en[d]` = 1;
  - not (`blink_mask[d]` and `blink_phase`).
- **Decode, before polarity inversion:**
  - Lit: `out_addr` = 1<<d and `out_data` = `display[d]`.
  - Dark: both are zero.
- `brightness`, `digit_en` and `blink_mask` are sampled live each cycle; no buffering.

## Timing
- Outputs are registered: outputs after edge n+1 are the decode of the state after edge n, a one-cycle latency. `frame_start` follows the same latency: it is high while the outputs reflect state (0,0).
- **Reset values (asynchronous):**
  - `d`=0, `t`=0, `f`=0, `blink_phase`=0, `shadow`=0, `display`=0, `pending`=0.
  - `frame_start`=0, `update_pending`=0.
  - `out_addr` all inactive: 0, or all-ones if `ADDR_ACTIVE_LOW`.
  - `out_data` all inactive: 0, or all-ones if `SEG_ACTIVE_LOW`.
- Reset mid-frame returns immediately to the reset values. Any pending shadow data is discarded.
- Frame period is NUM_DIGITS*SLOT_TICKS cycles. The duty per digit is `brightness`/(NUM_DIGITS*SLOT_TICKS).
- `out_addr` is never multi-hot. At least one dark cycle (tick 0) separates consecutive digits.
- `update_pending` is the registered `pending`. It rises the cycle after `load` and falls the cycle after the frame end.
- A new `display` value is first visible on the first lit cycle of digit 0 of the next frame. No frame shows mixed old and new data.

## Test plan
- **Reset:** assert `rst` mid-frame with polarity params 0/0 -> `out_addr`=0 and `out_data`=0 immediately. After release, first `frame_start` is at edge 1. `update_pending`=0.
- **Full-brightness scan:** NUM_DIGITS=4, BRIGHT_WIDTH=2, load {0x88,0x44,0x22,0x11}, brightness=3, all enabled -> per digit 1 dark cycle, then 3 cycles of `out_addr`=0001/0x11, 0010/0x22, 0100/0x44, 1000/0x88. Frame period is 16 cycles.
- **Deferred load:** load 0xFF-all at digit 1 tick 2 -> `update_pending` high, digits 1..3 keep old data, new data appears from digit 0 of the next frame, `update_pending` drops at the frame end. A load exactly on the frame-end cycle -> visible next frame, `update_pending` stays 0.
- **Brightness and enable:** brightness=0 -> outputs always inactive. brightness=1 -> one lit cycle per slot. `digit_en`=4'b1010 -> digits 0 and 2 dark, with no addr bit asserted for them.
- **Blink:** BLINK_FRAMES=2, `blink_mask`=0001 -> digit 0 lit for frames 0-1, dark for frames 2-3, lit again from frame 4. Other digits unaffected.
- **Polarity:** ADDR_ACTIVE_LOW=1, SEG_ACTIVE_LOW=1 -> reset `out_addr`=1111 and `out_data`=0xFF. Digit 2 lit with 0x3C gives `out_addr`=1011 and `out_data`=0xC3.

Source files
------------

// File: rtl/segment_scanner.sv
`timescale 1ns/1ps
`default_nettype none
// ============================================================================
// Module   : segment_scanner
// Purpose  : Time-multiplexed segment display driver with per-slot dead-time,
//            PWM brightness, per-digit enable/blink and a double-buffered
//            character load that only lands on frame boundaries.
// Revision : 1.0 - initial release
// ============================================================================
module segment_scanner #(
  parameter int NUM_DIGITS      = 4,
  parameter int SEG_WIDTH       = 8,
  parameter int BRIGHT_WIDTH    = 4,
  parameter int BLINK_FRAMES    = 64,
  parameter int ADDR_ACTIVE_LOW = 0,
  parameter int SEG_ACTIVE_LOW  = 0
) (
  input  logic                                clk_div,
  input  logic                                rst,
  input  logic [NUM_DIGITS-1:0][SEG_WIDTH-1:0] chars,
  input  logic                                load,
  input  logic [BRIGHT_WIDTH-1:0]             brightness,
  input  logic [NUM_DIGITS-1:0]               digit_en,
  input  logic [NUM_DIGITS-1:0]               blink_mask,
  output logic [NUM_DIGITS-1:0]               out_addr,
  output logic [SEG_WIDTH-1:0]                out_data,
  output logic                                update_pending,
  output logic                                frame_start
);

  localparam int c_D_W = (NUM_DIGITS > 1) ? $clog2(NUM_DIGITS) : 1;
  localparam int c_F_W = (BLINK_FRAMES > 1) ? $clog2(BLINK_FRAMES) : 1;

  localparam logic [c_D_W-1:0]        c_LAST_D    = c_D_W'(NUM_DIGITS - 1);
  localparam logic [BRIGHT_WIDTH-1:0] c_LAST_T    = {BRIGHT_WIDTH{1'b1}};
  localparam logic [c_F_W-1:0]        c_LAST_F    = c_F_W'(BLINK_FRAMES - 1);
  localparam logic                    c_ADDR_INV  = (ADDR_ACTIVE_LOW != 0);
  localparam logic                    c_DATA_INV  = (SEG_ACTIVE_LOW != 0);
  localparam logic [NUM_DIGITS-1:0]   c_ADDR_IDLE = {NUM_DIGITS{c_ADDR_INV}};
  localparam logic [SEG_WIDTH-1:0]    c_DATA_IDLE = {SEG_WIDTH{c_DATA_INV}};

  logic [c_D_W-1:0]                    r_d;
  logic [BRIGHT_WIDTH-1:0]             r_t;
  logic [c_F_W-1:0]                    r_f;
  logic                                r_blink;
  logic [NUM_DIGITS-1:0][SEG_WIDTH-1:0] r_shadow;
  logic [NUM_DIGITS-1:0][SEG_WIDTH-1:0] r_display;
  logic                                r_pending;

  logic                                w_slot_end;
  logic                                w_frame_end;
  logic                                w_lit;
  logic [NUM_DIGITS-1:0]               w_addr;
  logic [SEG_WIDTH-1:0]                w_data;

  assign w_slot_end  = (r_t == c_LAST_T);
  assign w_frame_end = w_slot_end && (r_d == c_LAST_D);

  // Slot tick and digit index: tick runs every cycle, digit advances per slot.
  always_ff @(posedge clk_div or posedge rst) begin
    if (rst) begin
      r_t <= '0;
      r_d <= '0;
    end else begin
      if (w_slot_end) begin
        r_t <= '0;
        r_d <= (r_d == c_LAST_D) ? '0 : r_d + 1'b1;
      end else begin
        r_t <= r_t + 1'b1;
      end
    end
  end

  // Blink timebase: frame counter toggles the phase only at frame ends.
  always_ff @(posedge clk_div or posedge rst) begin
    if (rst) begin
      r_f     <= '0;
      r_blink <= 1'b0;
    end else if (w_frame_end) begin
      if (r_f == c_LAST_F) begin
        r_f     <= '0;
        r_blink <= ~r_blink;
      end else begin
        r_f <= r_f + 1'b1;
      end
    end
  end

  // Double buffer: loads park in shadow, the display copy only changes at a
  // frame end so no frame ever mixes old and new characters.
  always_ff @(posedge clk_div or posedge rst) begin
    if (rst) begin
      r_shadow  <= '0;
      r_display <= '0;
      r_pending <= 1'b0;
    end else begin
      if (load) begin
        r_shadow <= chars;
        if (w_frame_end) begin
          r_display <= chars;
          r_pending <= 1'b0;
        end else begin
          r_pending <= 1'b1;
        end
      end else if (w_frame_end && r_pending) begin
        r_display <= r_shadow;
        r_pending <= 1'b0;
      end
    end
  end

  // Decode current slot: tick 0 is always dark, then brightness-limited PWM.
  always_comb begin
    w_addr = '0;
    w_data = '0;
    w_lit  = (r_t != '0) && (r_t <= brightness) && digit_en[r_d] &&
             !(blink_mask[r_d] && r_blink);
    if (w_lit) begin
      w_addr[r_d] = 1'b1;
      w_data      = r_display[r_d];
    end
  end

  // Output register: one cycle behind the scan state, polarity applied here.
  always_ff @(posedge clk_div or posedge rst) begin
    if (rst) begin
      out_addr       <= c_ADDR_IDLE;
      out_data       <= c_DATA_IDLE;
      frame_start    <= 1'b0;
      update_pending <= 1'b0;
    end else begin
      out_addr       <= w_addr ^ c_ADDR_IDLE;
      out_data       <= w_data ^ c_DATA_IDLE;
      frame_start    <= (r_d == '0) && (r_t == '0);
      update_pending <= r_pending;
    end
  end

endmodule
`default_nettype wire

// File: tb/tb_segment_scanner.sv
`timescale 1ns/1ps
`default_nettype none
// ============================================================================
// Module   : tb_segment_scanner
// Purpose  : Self-checking bench for segment_scanner (4 digits, 4-tick slots,
//            2-frame blink) plus an inverted-polarity instance.
// Revision : 1.0 - initial release
// ============================================================================
module tb_segment_scanner;

  localparam int N  = 4;
  localparam int S  = 8;
  localparam int BW = 2;
  localparam int BF = 2;

  logic                clk_div = 1'b0;
  logic                rst;
  logic [N-1:0][S-1:0] chars, chars2;
  logic                load, load2;
  logic [BW-1:0]       brightness, brightness2;
  logic [N-1:0]        digit_en, blink_mask, digit_en2, blink_mask2;
  logic [N-1:0]        out_addr, out_addr2;
  logic [S-1:0]        out_data, out_data2;
  logic                update_pending, frame_start, update_pending2, frame_start2;

  always #5 clk_div = ~clk_div;

  segment_scanner #(
    .NUM_DIGITS(N), .SEG_WIDTH(S), .BRIGHT_WIDTH(BW), .BLINK_FRAMES(BF),
    .ADDR_ACTIVE_LOW(0), .SEG_ACTIVE_LOW(0)
  ) dut (
    .clk_div(clk_div), .rst(rst), .chars(chars), .load(load),
    .brightness(brightness), .digit_en(digit_en), .blink_mask(blink_mask),
    .out_addr(out_addr), .out_data(out_data),
    .update_pending(update_pending), .frame_start(frame_start)
  );

  segment_scanner #(
    .NUM_DIGITS(N), .SEG_WIDTH(S), .BRIGHT_WIDTH(BW), .BLINK_FRAMES(BF),
    .ADDR_ACTIVE_LOW(1), .SEG_ACTIVE_LOW(1)
  ) dut_inv (
    .clk_div(clk_div), .rst(rst), .chars(chars2), .load(load2),
    .brightness(brightness2), .digit_en(digit_en2), .blink_mask(blink_mask2),
    .out_addr(out_addr2), .out_data(out_data2),
    .update_pending(update_pending2), .frame_start(frame_start2)
  );

  int tests = 0;
  int fails = 0;

  typedef struct {
    logic [3:0] addr;
    logic [7:0] data;
    logic       fs;
    logic       up;
  } exp_t;
  exp_t sbq[$];

  typedef struct {
    logic [1:0] br;
    logic [3:0] en;
    int         cyc;
    logic [3:0] addr;
    logic [7:0] data;
  } vec_t;
  vec_t vecs[15];

  // Reference scan model of the main instance
  int                  m_d, m_t, m_f;
  bit                  m_bp, m_pend;
  logic [N-1:0][S-1:0] m_sh, m_disp;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] req);
    tests++;
    if (act !== req) begin
      fails++;
      $display("FAIL %s: actual %0h required %0h", name, act, req);
    end
  endtask

  task automatic model_reset();
    m_d = 0; m_t = 0; m_f = 0; m_bp = 0; m_pend = 0;
    m_sh = '0; m_disp = '0;
    sbq.delete();
  endtask

  // One clock: predict outputs from the pre-edge state, advance the model,
  // then compare against the DUT half a cycle after the edge.
  task automatic cyc();
    exp_t e;
    bit   lit;
    bit   fe;
    lit    = (m_t != 0) && (m_t <= int'(brightness)) && (digit_en[m_d] == 1'b1) &&
             !((blink_mask[m_d] == 1'b1) && m_bp);
    e.addr = lit ? 4'(1 << m_d) : 4'h0;
    e.data = lit ? m_disp[m_d] : 8'h00;
    e.fs   = (m_d == 0 && m_t == 0);
    e.up   = m_pend;
    sbq.push_back(e);
    fe = (m_d == N - 1) && (m_t == (1 << BW) - 1);
    if (load) begin
      m_sh = chars;
      if (fe) begin m_disp = chars; m_pend = 0; end
      else m_pend = 1;
    end else if (fe && m_pend) begin
      m_disp = m_sh;
      m_pend = 0;
    end
    if (fe) begin
      if (m_f == BF - 1) begin m_f = 0; m_bp = !m_bp; end
      else m_f++;
    end
    if (m_t == (1 << BW) - 1) begin m_t = 0; m_d = (m_d + 1) % N; end
    else m_t++;
    @(posedge clk_div);
    @(negedge clk_div);
    e = sbq.pop_front();
    tests++;
    if (out_addr !== e.addr || out_data !== e.data ||
        frame_start !== e.fs || update_pending !== e.up) begin
      fails++;
      $display("FAIL scoreboard t=%0t: actual addr=%b data=%h fs=%b up=%b required addr=%b data=%h fs=%b up=%b",
               $time, out_addr, out_data, frame_start, update_pending, e.addr, e.data, e.fs, e.up);
    end
  endtask

  // Advance until the model state is (d,t) just before the next edge.
  task automatic align(input int d, input int t);
    int n = 0;
    while (!(m_d == d && m_t == t) && n < 100) begin cyc(); n++; end
    if (!(m_d == d && m_t == t)) begin
      fails++;
      $display("FAIL align: actual timeout required state %0d/%0d", d, t);
    end
  endtask

  initial begin
    int n;
    int cnt;
    rst = 1'b1; load = 1'b0; chars = '0; brightness = '0; digit_en = '0; blink_mask = '0;
    load2 = 1'b0; chars2 = '0; brightness2 = '0; digit_en2 = '0; blink_mask2 = '0;
    model_reset();

    vecs[0]  = '{2'd3, 4'hF,  0, 4'h0, 8'h00};
    vecs[1]  = '{2'd3, 4'hF,  1, 4'h1, 8'h11};
    vecs[2]  = '{2'd3, 4'hF,  3, 4'h1, 8'h11};
    vecs[3]  = '{2'd3, 4'hF,  4, 4'h0, 8'h00};
    vecs[4]  = '{2'd3, 4'hF,  5, 4'h2, 8'h22};
    vecs[5]  = '{2'd3, 4'hF, 10, 4'h4, 8'h44};
    vecs[6]  = '{2'd3, 4'hF, 15, 4'h8, 8'h88};
    vecs[7]  = '{2'd1, 4'hF,  1, 4'h1, 8'h11};
    vecs[8]  = '{2'd1, 4'hF,  2, 4'h0, 8'h00};
    vecs[9]  = '{2'd1, 4'hF, 13, 4'h8, 8'h88};
    vecs[10] = '{2'd0, 4'hF,  1, 4'h0, 8'h00};
    vecs[11] = '{2'd0, 4'hF,  9, 4'h0, 8'h00};
    vecs[12] = '{2'd3, 4'hA,  2, 4'h0, 8'h00};
    vecs[13] = '{2'd3, 4'hA,  6, 4'h2, 8'h22};
    vecs[14] = '{2'd3, 4'hA, 10, 4'h0, 8'h00};

    // Reset values on both polarities
    @(negedge clk_div);
    @(negedge clk_div);
    check("rst_addr", out_addr, 4'h0);
    check("rst_data", out_data, 8'h00);
    check("rst_fs", frame_start, 1'b0);
    check("rst_up", update_pending, 1'b0);
    check("rst_addr_inv", out_addr2, 4'hF);
    check("rst_data_inv", out_data2, 8'hFF);

    rst = 1'b0;
    brightness = 2'd3;
    digit_en   = 4'hF;
    cyc();
    check("first_frame_start", frame_start, 1'b1);

    // Initial content load on both instances
    chars  = {8'h88, 8'h44, 8'h22, 8'h11}; load  = 1'b1;
    chars2 = {8'h00, 8'h3C, 8'h00, 8'h00}; load2 = 1'b1; brightness2 = 2'd3;
    cyc();
    load = 1'b0; load2 = 1'b0;
    cyc();
    check("up_rise", update_pending, 1'b1);

    // Table-driven scan vectors, each indexed from the start of a frame
    foreach (vecs[i]) begin
      brightness = vecs[i].br;
      digit_en   = vecs[i].en;
      align(0, 0);
      repeat (vecs[i].cyc + 1) cyc();
      check($sformatf("vec%0d_addr", i), out_addr, vecs[i].addr);
      check($sformatf("vec%0d_data", i), out_data, vecs[i].data);
    end
    brightness = 2'd3;
    digit_en   = 4'hF;

    // Frame period between frame_start pulses
    n = 0;
    while (frame_start !== 1'b1 && n < 40) begin cyc(); n++; end
    cnt = 0;
    do begin cyc(); cnt++; end while (frame_start !== 1'b1 && cnt < 40);
    check("frame_period", cnt, 16);

    // Deferred load mid-frame
    align(1, 2);
    chars = {4{8'hFF}}; load = 1'b1;
    cyc();
    load = 1'b0;
    align(2, 1); cyc();
    check("defer_old_d2", out_data, 8'h44);
    check("defer_pending", update_pending, 1'b1);
    align(3, 1); cyc();
    check("defer_old_d3", out_data, 8'h88);
    align(0, 1); cyc();
    check("defer_new_d0", out_data, 8'hFF);
    check("defer_up_drop", update_pending, 1'b0);

    // Load exactly on the frame-end cycle
    align(3, 3);
    chars = {8'hAA, 8'hBB, 8'hCC, 8'hDD}; load = 1'b1;
    cyc();
    load = 1'b0;
    align(0, 1); cyc();
    check("fe_load_d0", out_data, 8'hDD);
    check("fe_load_up", update_pending, 1'b0);

    // Blink on digit 0 over five frames
    blink_mask = 4'b0001;
    n = 0;
    while (!(m_d == 0 && m_t == 0 && m_f == 0 && !m_bp) && n < 200) begin cyc(); n++; end
    for (int fr = 0; fr < 5; fr++) begin
      for (int k = 0; k < 16; k++) begin
        cyc();
        if (k == 1) check($sformatf("blink_f%0d_d0", fr), out_addr, (fr == 2 || fr == 3) ? 4'h0 : 4'h1);
        if (k == 5) check($sformatf("blink_f%0d_d1", fr), out_addr, 4'h2);
      end
    end
    blink_mask = 4'b0000;

    // Inverted polarity: only digit 2 enabled, pattern 0x3C
    digit_en2 = 4'b0100;
    n = 0;
    while (out_addr2 === 4'hF && n < 100) begin cyc(); n++; end
    check("inv_addr", out_addr2, 4'b1011);
    check("inv_data", out_data2, 8'hC3);

    // Asynchronous reset mid-frame with a load still pending
    align(1, 2);
    chars = {4{8'h55}}; load = 1'b1;
    cyc();
    load = 1'b0;
    cyc();
    check("pre_rst_up", update_pending, 1'b1);
    #2 rst = 1'b1;
    #1;
    check("async_rst_addr", out_addr, 4'h0);
    check("async_rst_data", out_data, 8'h00);
    check("async_rst_up", update_pending, 1'b0);
    check("async_rst_addr_inv", out_addr2, 4'hF);
    @(negedge clk_div);
    rst = 1'b0;
    model_reset();
    cyc();
    check("post_rst_fs", frame_start, 1'b1);
    align(0, 1); cyc();
    check("discard_addr", out_addr, 4'h1);
    check("discard_data", out_data, 8'h00);
    check("discard_up", update_pending, 1'b0);

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
`default_nettype wire
